// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode bus for the IF/ID buffer: the upstream fetch handshake, the
// downstream decode handshake, the redirect flush and the occupancy debug view.
interface if_id_buffer_if #(
  parameter int XLEN = 32
);
  // valid/ready: an entry moves across a side on a rising edge where valid and
  // ready are both high; the sender holds its payload stable while valid is high
  // and ready is low, and flush_i cancels any transfer on the same edge.
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] inst_i;
  logic            valid_i;
  logic            ready_o;
  logic            flush_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] inst_o;
  logic            valid_o;
  logic            ready_i;
  logic [1:0]      count_o;

  modport slave (
    input  pc_i,
    input  inst_i,
    input  valid_i,
    input  flush_i,
    input  ready_i,
    output ready_o,
    output pc_o,
    output inst_o,
    output valid_o,
    output count_o
  );

  modport master (
    output pc_i,
    output inst_i,
    output valid_i,
    output flush_i,
    output ready_i,
    input  ready_o,
    input  pc_o,
    input  inst_o,
    input  valid_o,
    input  count_o
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID decoupling stage: a 2-entry skid FIFO of {pc, inst} pairs with fully
// registered handshakes, so decode can stall without fetch dropping a word.
module if_id_buffer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input logic           clk_i,
  input logic           rst_i,
  if_id_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e            occ_q, occ_d;
  logic [XLEN-1:0] e0_pc_q, e0_pc_d;
  logic [XLEN-1:0] e0_inst_q, e0_inst_d;
  logic [XLEN-1:0] e1_pc_q, e1_pc_d;
  logic [XLEN-1:0] e1_inst_q, e1_inst_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            push;
  logic            pop;

  assign in_pc   = bus.pc_i;
  assign in_inst = bus.inst_i;

  // Both qualifiers use registered ready/valid only, so no input reaches an
  // output of the same side combinationally.
  assign push = bus.valid_i & ready_q & ~bus.flush_i;
  assign pop  = valid_q & bus.ready_i & ~bus.flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ_q     <= OCC_EMPTY;
      e0_pc_q   <= '0;
      e0_inst_q <= NOP_INST;
      e1_pc_q   <= '0;
      e1_inst_q <= NOP_INST;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      occ_q     <= occ_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    occ_d     = occ_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;

    if (bus.flush_i) begin
      occ_d     = OCC_EMPTY;
      e0_pc_d   = '0;
      e0_inst_d = NOP_INST;
      e1_pc_d   = '0;
      e1_inst_d = NOP_INST;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            e0_pc_d   = in_pc;
            e0_inst_d = in_inst;
            occ_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            e0_pc_d   = in_pc;
            e0_inst_d = in_inst;
          end else if (push) begin
            e1_pc_d   = in_pc;
            e1_inst_d = in_inst;
            occ_d     = OCC_FULL;
          end else if (pop) begin
            e0_pc_d   = '0;
            e0_inst_d = NOP_INST;
            occ_d     = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // ready_q is low here, so only a pop can happen.
          if (pop) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
            e1_pc_d   = '0;
            e1_inst_d = NOP_INST;
            occ_d     = OCC_ONE;
          end
        end
        default: begin
          occ_d     = OCC_EMPTY;
          e0_pc_d   = '0;
          e0_inst_d = NOP_INST;
          e1_pc_d   = '0;
          e1_inst_d = NOP_INST;
        end
      endcase
    end

    valid_d = (occ_d != OCC_EMPTY);
    ready_d = (occ_d != OCC_FULL);
  end

  assign bus.pc_o    = e0_pc_q;
  assign bus.inst_o  = e0_inst_q;
  assign bus.valid_o = valid_q;
  assign bus.ready_o = ready_q;
  assign bus.count_o = occ_q;

endmodule
